storage_req_server: RTL and testbench

- Shared read-service stage directly downstream of the per-core storage control units.
- Queues the 12-bit {core_number, addr} read requests that the granted core writes, serves them one at a time against the single-port storage, and returns the read data to that core.
- Returns completion to the requesting core as a one-hot txn_done pulse.

---
 rtl/storage_pkg.sv | 27 ++
 rtl/storage_req_fifo.sv | 72 +++++++
 rtl/storage_req_server.sv | 161 ++++++++++++++++
 tb/tb_storage_req_server.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/storage_pkg.sv
// Shared types and request-field helpers for the storage read-service stage.
// A request word is {core_number, addr}.
package storage_pkg;

  // Service FSM states
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  localparam int NUM_W  = 4;
  localparam int ADDR_W = 8;
  localparam int REQ_W  = NUM_W + ADDR_W;

  // Core number field of a request word
  function automatic logic [NUM_W-1:0] req_num(input logic [REQ_W-1:0] req);
    return req[REQ_W-1:ADDR_W];
  endfunction

  // Storage address field of a request word
  function automatic logic [ADDR_W-1:0] req_addr(input logic [REQ_W-1:0] req);
    return req[ADDR_W-1:0];
  endfunction

endpackage

// File: rtl/storage_req_fifo.sv
// Synchronous request FIFO with registered full flag and occupancy count.
// The head entry is read asynchronously so the server can pop and latch it
// in the same cycle. A push while full is ignored.
module storage_req_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, full_d;
  logic             do_push, do_pop;

  assign do_push = push && !full_q;
  assign do_pop  = pop && (count_q != '0);

  // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-two depth)
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    full_d = (count_d == CNT_W'(DEPTH));
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
    end
  end

  // Storage array write; contents need no reset since pointers gate validity
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign full    = full_q;
  assign empty   = (count_q == '0);
  assign count   = count_q;

endmodule

// File: rtl/storage_req_server.sv
// Shared read-service stage: queues {core_number, addr} requests, performs
// one storage read at a time and returns the data with a one-hot txn_done.
// Optional macro STORAGE_REQ_BYPASS_EN lets a request arriving at an idle,
// empty block skip the FIFO and issue one cycle earlier.
module storage_req_server #(
  parameter int DEPTH       = 8,
  parameter int NUM_CORES   = 4,
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 32,
  parameter int NUM_W       = 4,
  parameter int MEM_LATENCY = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_wr,
  input  logic [NUM_W+ADDR_W-1:0]  req_data,
  output logic                     req_full,
  output logic [$clog2(DEPTH):0]   req_count,
  output logic                     mem_en,
  output logic [ADDR_W-1:0]        mem_addr,
  input  logic [DATA_W-1:0]        mem_rdata,
  output logic [DATA_W-1:0]        rsp_data,
  output logic [NUM_CORES-1:0]     txn_done,
  output logic                     err_overflow,
  output logic                     err_badnum
);

  import storage_pkg::*;

  localparam int                 LAT_W    = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [LAT_W-1:0]   LAT_LOAD = LAT_W'(MEM_LATENCY - 1);
  localparam logic [NUM_W-1:0]   MAX_NUM  = NUM_W'(NUM_CORES);

`ifdef STORAGE_REQ_BYPASS_EN
  localparam bit BYPASS_EN = 1'b1;
`else
  localparam bit BYPASS_EN = 1'b0;
`endif

  state_e                  state_q, state_d;
  logic [NUM_W-1:0]        num_q, num_d;
  logic [LAT_W-1:0]        lat_q, lat_d;
  logic                    mem_en_q, mem_en_d;
  logic [ADDR_W-1:0]       mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]       rsp_q, rsp_d;
  logic [NUM_CORES-1:0]    txn_q, txn_d;
  logic                    ovf_q, ovf_d;
  logic                    bad_q, bad_d;

  logic                    fifo_push, fifo_pop, fifo_empty;
  logic [NUM_W+ADDR_W-1:0] fifo_rd, head;
  logic                    take, bypass;

  storage_req_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (NUM_W + ADDR_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .wr_data (req_data),
    .rd_data (fifo_rd),
    .full    (req_full),
    .empty   (fifo_empty),
    .count   (req_count)
  );

  // Service FSM: pick up a request, issue the read, wait out the latency, respond
  always_comb begin
    state_d    = state_q;
    num_d      = num_q;
    lat_d      = lat_q;
    mem_addr_d = mem_addr_q;
    rsp_d      = rsp_q;
    bad_d      = bad_q;
    mem_en_d   = 1'b0;
    fifo_pop   = 1'b0;
    take       = 1'b0;
    bypass     = 1'b0;
    head       = fifo_rd;
    case (state_q)
      S_IDLE: begin
        if (BYPASS_EN && fifo_empty && req_wr) begin
          bypass = 1'b1;
          take   = 1'b1;
          head   = req_data;
        end else if (!fifo_empty) begin
          fifo_pop = 1'b1;
          take     = 1'b1;
        end
        if (take) begin
          // Unknown requesters are dropped without touching storage
          if (req_num(head) == '0 || req_num(head) > MAX_NUM) begin
            bad_d = 1'b1;
          end else begin
            num_d      = req_num(head);
            mem_addr_d = req_addr(head);
            mem_en_d   = 1'b1;
            state_d    = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        lat_d   = LAT_LOAD;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (lat_q == '0) begin
          rsp_d   = mem_rdata;
          state_d = S_RESP;
        end else begin
          lat_d = lat_q - LAT_W'(1);
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // A write while full is dropped even if a pop happens in the same cycle
    fifo_push = req_wr && !bypass;
    ovf_d     = ovf_q || (req_wr && req_full);
  end

  // One-hot completion, raised for the cycle the FSM sits in RESP
  for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_done
    assign txn_d[gi] = (state_d == S_RESP) && (num_q == NUM_W'(gi + 1));
  end

  // State registers; reset abandons any in-flight read
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      num_q      <= '0;
      lat_q      <= '0;
      mem_en_q   <= 1'b0;
      mem_addr_q <= '0;
      rsp_q      <= '0;
      txn_q      <= '0;
      ovf_q      <= 1'b0;
      bad_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      num_q      <= num_d;
      lat_q      <= lat_d;
      mem_en_q   <= mem_en_d;
      mem_addr_q <= mem_addr_d;
      rsp_q      <= rsp_d;
      txn_q      <= txn_d;
      ovf_q      <= ovf_d;
      bad_q      <= bad_d;
    end
  end

  assign mem_en       = mem_en_q;
  assign mem_addr     = mem_addr_q;
  assign rsp_data     = rsp_q;
  assign txn_done     = txn_q;
  assign err_overflow = ovf_q;
  assign err_badnum   = bad_q;

endmodule

// File: tb/tb_storage_req_server.sv
// Bench for storage_req_server: directed scenarios plus random traffic,
// checked every cycle against a transaction-schedule reference model.
module tb_storage_req_server;

  localparam int DEPTH = 8;
  localparam int NC    = 4;
  localparam int LAT   = 2;
`ifdef STORAGE_REQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam int EN_LAT = BYP ? 1 : 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_wr;
  logic [11:0] req_data;
  logic        req_full;
  logic [3:0]  req_count;
  logic        mem_en;
  logic [7:0]  mem_addr;
  logic [31:0] mem_rdata;
  logic [31:0] rsp_data;
  logic [3:0]  txn_done;
  logic        err_overflow;
  logic        err_badnum;

  storage_req_server #(
    .DEPTH(DEPTH), .NUM_CORES(NC), .ADDR_W(8), .DATA_W(32), .NUM_W(4), .MEM_LATENCY(LAT)
  ) dut (
    .clk(clk), .rst(rst), .req_wr(req_wr), .req_data(req_data),
    .req_full(req_full), .req_count(req_count), .mem_en(mem_en), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .rsp_data(rsp_data), .txn_done(txn_done),
    .err_overflow(err_overflow), .err_badnum(err_badnum)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Reference model: FIFO contents plus the cycle schedule of the current transaction
  logic [11:0] mq[$];
  int          idle_at, issue_at, cap_at, done_at;
  logic [3:0]  m_num;
  logic [7:0]  m_addr;
  logic [31:0] m_rsp;
  bit          m_ovf, m_bad;

  // Observation bookkeeping
  bit          use_fix = 1'b0;
  logic [31:0] rdata_fix = '0;
  int          en_count, done_count, last_en_cyc, last_done_cyc, peak;
  logic [3:0]  last_done_val;
  bit          saw_full;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Advance the model across the clock edge that ends cycle k
  task automatic model_update(input logic wr, input logic [11:0] d, input logic [31:0] rd, input logic r);
    int k;
    bit full, taken, byp;
    logic [11:0] h;
    logic [3:0] n;
    k = cyc;
    if (r) begin
      mq.delete();
      idle_at = 0; issue_at = -1; cap_at = -1; done_at = -1;
      m_num = '0; m_addr = '0; m_rsp = '0; m_ovf = 1'b0; m_bad = 1'b0;
      return;
    end
    if (k == cap_at) m_rsp = rd;
    full  = (mq.size() == DEPTH);
    taken = 1'b0;
    byp   = 1'b0;
    h     = '0;
    if (k >= idle_at) begin
      if (BYP && mq.size() == 0 && wr) begin
        h = d; taken = 1'b1; byp = 1'b1;
      end else if (mq.size() > 0) begin
        h = mq.pop_front(); taken = 1'b1;
      end
    end
    if (taken) begin
      n = h[11:8];
      if (n == 4'd0 || n > 4'(NC)) begin
        m_bad = 1'b1;
      end else begin
        m_num    = n;
        m_addr   = h[7:0];
        issue_at = k + 1;
        cap_at   = k + 1 + LAT;
        done_at  = k + 2 + LAT;
        idle_at  = k + 3 + LAT;
      end
    end
    if (wr && !byp) begin
      if (full) m_ovf = 1'b1;
      else mq.push_back(d);
    end
  endtask

  task automatic check_all();
    logic [3:0] exp_done;
    exp_done = (cyc == done_at) ? (4'b0001 << (m_num - 4'd1)) : 4'b0000;
    chk("mem_en", mem_en, cyc == issue_at);
    chk("mem_addr", mem_addr, m_addr);
    chk("txn_done", txn_done, exp_done);
    chk("rsp_data", rsp_data, m_rsp);
    chk("req_count", req_count, mq.size());
    chk("req_full", req_full, mq.size() == DEPTH);
    chk("err_overflow", err_overflow, m_ovf);
    chk("err_badnum", err_badnum, m_bad);
    chk("done_onehot", $countones(txn_done) <= 1, 1'b1);
    if (mem_en) begin en_count++; last_en_cyc = cyc; end
    if (|txn_done) begin
      done_count++; last_done_cyc = cyc; last_done_val = txn_done;
      $display("txn: cycle %0d done=%b data=%h", cyc, txn_done, rsp_data);
    end
    if (int'(req_count) > peak) peak = int'(req_count);
    if (req_full) saw_full = 1'b1;
  endtask

  // One clock cycle: drive inputs, cross the edge, update model, check outputs
  task automatic tick(input logic wr, input logic [11:0] d, input logic r);
    logic [31:0] rd;
    rd = use_fix ? rdata_fix : 32'($urandom);
    req_wr = wr; req_data = d; rst = r; mem_rdata = rd;
    @(posedge clk);
    model_update(wr, d, rd, r);
    cyc++;
    #1;
    check_all();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t;
    int exp_done_t3;
    req_wr = 1'b0; req_data = '0; rst = 1'b1; mem_rdata = '0;
    en_count = 0; done_count = 0; last_en_cyc = -1; last_done_cyc = -1;
    last_done_val = '0; peak = 0; saw_full = 1'b0;

    // Reset state
    tick(1'b0, 12'h000, 1'b1);
    tick(1'b0, 12'h000, 1'b1);
    chk("reset_count", req_count, 0);
    chk("reset_txn", txn_done, 0);

    // Single request, fixed read data
    use_fix = 1'b1; rdata_fix = 32'hDEAD_BEEF;
    t = cyc;
    tick(1'b1, 12'h13C, 1'b0);
    repeat (8) tick(1'b0, 12'h000, 1'b0);
    chk("t1_en_cycle", last_en_cyc, t + EN_LAT);
    chk("t1_mem_addr", mem_addr, 8'h3C);
    chk("t1_done_cycle", last_done_cyc, t + EN_LAT + LAT + 1);
    chk("t1_done_val", last_done_val, 4'b0001);
    chk("t1_rsp", rsp_data, 32'hDEAD_BEEF);
    use_fix = 1'b0;

    // Back-to-back requests from cores 1..4
    en_count = 0; done_count = 0; peak = 0;
    for (int i = 0; i < 4; i++) tick(1'b1, {4'(i + 1), 8'(i)}, 1'b0);
    repeat (25) tick(1'b0, 12'h000, 1'b0);
    chk("t2_en_count", en_count, 4);
    chk("t2_done_count", done_count, 4);
    chk("t2_last_done", last_done_val, 4'b1000);
    chk("t2_peak", peak, 3);

    // Overflow: more writes than the FIFO can hold while the server is busy
    done_count = 0; saw_full = 1'b0;
    for (int i = 0; i < 12; i++) tick(1'b1, {4'((i % 4) + 1), 8'(8'h10 + i)}, 1'b0);
    chk("t3_overflow", err_overflow, 1'b1);
    chk("t3_saw_full", saw_full, 1'b1);
    repeat (70) tick(1'b0, 12'h000, 1'b0);
    exp_done_t3 = BYP ? 11 : 10;
    chk("t3_done_count", done_count, exp_done_t3);
    chk("t3_drained", req_count, 0);

    // Bad core numbers, then a valid request
    en_count = 0; done_count = 0;
    tick(1'b1, 12'h011, 1'b0);
    tick(1'b1, 12'h722, 1'b0);
    repeat (6) tick(1'b0, 12'h000, 1'b0);
    chk("t4_badnum", err_badnum, 1'b1);
    chk("t4_no_en", en_count, 0);
    chk("t4_no_done", done_count, 0);
    tick(1'b1, 12'h233, 1'b0);
    repeat (8) tick(1'b0, 12'h000, 1'b0);
    chk("t4_valid_en", en_count, 1);
    chk("t4_valid_done", last_done_val, 4'b0010);

    // Reset while waiting on storage
    tick(1'b1, 12'h344, 1'b0);
    repeat (EN_LAT) tick(1'b0, 12'h000, 1'b0);
    tick(1'b0, 12'h000, 1'b1);
    chk("t5_txn", txn_done, 0);
    chk("t5_count", req_count, 0);
    chk("t5_rsp", rsp_data, 0);
    done_count = 0;
    repeat (10) tick(1'b0, 12'h000, 1'b0);
    chk("t5_no_late_done", done_count, 0);

    // Random traffic with occasional bad numbers and resets
    for (int i = 0; i < 400; i++) begin
      logic wr;
      logic [11:0] d;
      logic r;
      wr = ($urandom_range(0, 99) < 45);
      d  = {4'($urandom_range(0, 5)), 8'($urandom)};
      r  = ($urandom_range(0, 199) == 0);
      tick(wr, d, r);
    end
    repeat (60) tick(1'b0, 12'h000, 1'b0);
    chk("rand_drained", req_count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
